// File: rtl/trap_sequencer_pkg.sv
// Shared constants for the machine-mode trap sequencer: cause codes, CSR
// addresses, mstatus field positions, state encodings and mstatus update helpers.
package trap_sequencer_pkg;

    localparam int unsigned N      = 32;
    localparam int unsigned CSR_AW = 12;

    localparam logic [CSR_AW-1:0] CSR_MEPC    = 12'h341;
    localparam logic [CSR_AW-1:0] CSR_MCAUSE  = 12'h342;
    localparam logic [CSR_AW-1:0] CSR_MTVAL   = 12'h343;
    localparam logic [CSR_AW-1:0] CSR_MSTATUS = 12'h300;

    localparam logic [N-1:0] CAUSE_PC_MIS    = 32'd0;
    localparam logic [N-1:0] CAUSE_ILLEGAL   = 32'd2;
    localparam logic [N-1:0] CAUSE_EBREAK    = 32'd3;
    localparam logic [N-1:0] CAUSE_LOAD_MIS  = 32'd4;
    localparam logic [N-1:0] CAUSE_STORE_MIS = 32'd6;
    localparam logic [N-1:0] CAUSE_ECALL     = 32'd11;
    localparam logic [N-1:0] CAUSE_MEI       = 32'h8000_000B;
    localparam logic [N-1:0] CAUSE_MSI       = 32'h8000_0003;

    // bit positions inside i_exc_vec
    localparam int unsigned EXC_PC_MIS    = 0;
    localparam int unsigned EXC_ILLEGAL   = 1;
    localparam int unsigned EXC_EBREAK    = 2;
    localparam int unsigned EXC_ECALL     = 3;
    localparam int unsigned EXC_LOAD_MIS  = 4;
    localparam int unsigned EXC_STORE_MIS = 5;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;
    localparam int unsigned MIE_MSIE       = 3;
    localparam int unsigned MIE_MEIE       = 11;

    localparam logic [N-1:0] PC_ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_DRAIN    = 3'd1;
    localparam logic [2:0] S_W_EPC    = 3'd2;
    localparam logic [2:0] S_W_CAUSE  = 3'd3;
    localparam logic [2:0] S_W_TVAL   = 3'd4;
    localparam logic [2:0] S_W_STATUS = 3'd5;
    localparam logic [2:0] S_REDIRECT = 3'd6;
    localparam logic [2:0] S_M_STATUS = 3'd7;

    function automatic logic [N-1:0] trap_mstatus(input logic [N-1:0] s);
        logic [N-1:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [N-1:0] mret_mstatus(input logic [N-1:0] s);
        logic [N-1:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_sequencer_prio_enc.sv
// Combinational trap priority encoder: synchronous exceptions first (fixed
// order), then machine external, then machine software interrupt.
module trap_prio_enc
    import trap_sequencer_pkg::*;
(
    input  logic         i_exc_valid,
    input  logic [5:0]   i_exc_vec,
    input  logic         i_glob_ie,
    input  logic         i_meie,
    input  logic         i_msie,
    input  logic         i_mei_pend,
    input  logic         i_msi_pend,
    output logic         o_take,
    output logic         o_is_intr,
    output logic [N-1:0] o_cause
);

    always_comb begin
        o_take    = 1'b0;
        o_is_intr = 1'b0;
        o_cause   = '0;
        if (i_exc_valid && (|i_exc_vec)) begin
            o_take = 1'b1;
            if (i_exc_vec[EXC_PC_MIS])       o_cause = CAUSE_PC_MIS;
            else if (i_exc_vec[EXC_ILLEGAL]) o_cause = CAUSE_ILLEGAL;
            else if (i_exc_vec[EXC_EBREAK])  o_cause = CAUSE_EBREAK;
            else if (i_exc_vec[EXC_ECALL])   o_cause = CAUSE_ECALL;
            else if (i_exc_vec[EXC_LOAD_MIS]) o_cause = CAUSE_LOAD_MIS;
            else                             o_cause = CAUSE_STORE_MIS;
        end else if (i_glob_ie && i_meie && i_mei_pend) begin
            o_take    = 1'b1;
            o_is_intr = 1'b1;
            o_cause   = CAUSE_MEI;
        end else if (i_glob_ie && i_msie && i_msi_pend) begin
            o_take    = 1'b1;
            o_is_intr = 1'b1;
            o_cause   = CAUSE_MSI;
        end
    end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: drains the pipeline, writes the
// trap CSRs one per cycle through the CSR write port, then redirects fetch.
module trap_sequencer
    import trap_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_exc_valid,
    input  logic [5:0]        i_exc_vec,
    input  logic [N-1:0]      i_exc_pc,
    input  logic [N-1:0]      i_exc_tval,
    input  logic              i_mret,
    input  logic              i_ext_intr,
    input  logic              i_sw_intr,
    input  logic [N-1:0]      i_next_pc,
    input  logic [N-1:0]      i_mstatus,
    input  logic [N-1:0]      i_mie,
    input  logic [N-1:0]      i_mtvec,
    input  logic [N-1:0]      i_mepc,
    input  logic              i_pipe_empty,
    output logic              o_flush,
    output logic              o_busy,
    output logic              o_csr_we,
    output logic [CSR_AW-1:0] o_csr_waddr,
    output logic [N-1:0]      o_csr_wdata,
    output logic              o_redirect,
    output logic [N-1:0]      o_redirect_pc
);

    logic [2:0]        r_state, w_nxt_state;
    logic [N-1:0]      r_cause, r_epc, r_tval, r_status;
    logic              r_flush, r_busy, r_csr_we, r_redirect;
    logic [CSR_AW-1:0] r_csr_waddr;
    logic [N-1:0]      r_csr_wdata, r_redirect_pc;

    logic              w_take, w_is_intr;
    logic [N-1:0]      w_cause;
    logic              w_idle, w_exc_acc, w_mret_acc, w_trap_acc;
    logic              w_csr_we, w_redirect;
    logic [CSR_AW-1:0] w_csr_waddr;
    logic [N-1:0]      w_csr_wdata, w_redirect_pc;
    logic [N-1:0]      w_trap_base, w_trap_pc;
    logic              w_unused_mie;

    trap_prio_enc u_prio (
        .i_exc_valid (i_exc_valid),
        .i_exc_vec   (i_exc_vec),
        .i_glob_ie   (i_mstatus[MSTATUS_MIE]),
        .i_meie      (i_mie[MIE_MEIE]),
        .i_msie      (i_mie[MIE_MSIE]),
        .i_mei_pend  (i_ext_intr),
        .i_msi_pend  (i_sw_intr),
        .o_take      (w_take),
        .o_is_intr   (w_is_intr),
        .o_cause     (w_cause)
    );

    assign w_unused_mie = ^{i_mie[N-1:12], i_mie[10:4], i_mie[2:0]};

    // Exception outranks MRET, which outranks any interrupt.
    assign w_idle     = (r_state == S_IDLE);
    assign w_exc_acc  = w_idle && w_take && !w_is_intr;
    assign w_mret_acc = w_idle && !w_exc_acc && i_mret;
    assign w_trap_acc = w_idle && w_take && !w_mret_acc;

    assign w_trap_base = {i_mtvec[N-1:2], 2'b00};
    assign w_trap_pc   = (i_mtvec[1:0] == 2'b01 && r_cause[N-1])
                       ? w_trap_base + N'({r_cause[4:0], 2'b00})
                       : w_trap_base;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt_state;
    end

    // Next state, then next-cycle output values decoded from that state.
    always_comb begin
        w_nxt_state   = r_state;
        w_csr_we      = 1'b0;
        w_csr_waddr   = '0;
        w_csr_wdata   = '0;
        w_redirect    = 1'b0;
        w_redirect_pc = '0;
        case (r_state)
            S_IDLE: begin
                if (w_trap_acc)      w_nxt_state = S_DRAIN;
                else if (w_mret_acc) w_nxt_state = S_M_STATUS;
            end
            S_DRAIN:    if (i_pipe_empty) w_nxt_state = S_W_EPC;
            S_W_EPC:    w_nxt_state = S_W_CAUSE;
            S_W_CAUSE:  w_nxt_state = S_W_TVAL;
            S_W_TVAL:   w_nxt_state = S_W_STATUS;
            S_W_STATUS: w_nxt_state = S_REDIRECT;
            S_M_STATUS: w_nxt_state = S_REDIRECT;
            S_REDIRECT: w_nxt_state = S_IDLE;
            default:    w_nxt_state = S_IDLE;
        endcase
        case (w_nxt_state)
            S_W_EPC: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = CSR_MEPC;
                w_csr_wdata = r_epc & PC_ALIGN_MASK;
            end
            S_W_CAUSE: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = CSR_MCAUSE;
                w_csr_wdata = r_cause;
            end
            S_W_TVAL: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = CSR_MTVAL;
                w_csr_wdata = r_tval;
            end
            S_W_STATUS: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = CSR_MSTATUS;
                w_csr_wdata = trap_mstatus(r_status);
            end
            S_M_STATUS: begin
                w_csr_we    = 1'b1;
                w_csr_waddr = CSR_MSTATUS;
                w_csr_wdata = mret_mstatus(i_mstatus);
            end
            S_REDIRECT: begin
                w_redirect    = 1'b1;
                w_redirect_pc = (r_state == S_M_STATUS) ? (i_mepc & PC_ALIGN_MASK) : w_trap_pc;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cause  <= '0;
            r_epc    <= '0;
            r_tval   <= '0;
            r_status <= '0;
        end else if (w_trap_acc) begin
            r_cause  <= w_cause;
            r_epc    <= w_is_intr ? i_next_pc : i_exc_pc;
            r_tval   <= w_is_intr ? '0 : i_exc_tval;
            r_status <= i_mstatus;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_flush       <= 1'b0;
            r_busy        <= 1'b0;
            r_csr_we      <= 1'b0;
            r_csr_waddr   <= '0;
            r_csr_wdata   <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
        end else begin
            r_flush       <= (w_nxt_state != S_IDLE);
            r_busy        <= (w_nxt_state != S_IDLE);
            r_csr_we      <= w_csr_we;
            r_csr_waddr   <= w_csr_waddr;
            r_csr_wdata   <= w_csr_wdata;
            r_redirect    <= w_redirect;
            r_redirect_pc <= w_redirect_pc;
        end
    end

    assign o_flush       = r_flush;
    assign o_busy        = r_busy;
    assign o_csr_we      = r_csr_we;
    assign o_csr_waddr   = r_csr_waddr;
    assign o_csr_wdata   = r_csr_wdata;
    assign o_redirect    = r_redirect;
    assign o_redirect_pc = r_redirect_pc;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: expected CSR writes and redirects are
// queued by each scenario and checked by a monitor as the DUT emits them.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_exc_valid, i_mret, i_ext_intr, i_sw_intr, i_pipe_empty;
    logic [5:0]  i_exc_vec;
    logic [31:0] i_exc_pc, i_exc_tval, i_next_pc, i_mstatus, i_mie, i_mtvec, i_mepc;
    logic        o_flush, o_busy, o_csr_we, o_redirect;
    logic [11:0] o_csr_waddr;
    logic [31:0] o_csr_wdata, o_redirect_pc;

    typedef struct packed {
        logic        redir;
        logic [11:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    trap_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .i_exc_valid   (i_exc_valid),
        .i_exc_vec     (i_exc_vec),
        .i_exc_pc      (i_exc_pc),
        .i_exc_tval    (i_exc_tval),
        .i_mret        (i_mret),
        .i_ext_intr    (i_ext_intr),
        .i_sw_intr     (i_sw_intr),
        .i_next_pc     (i_next_pc),
        .i_mstatus     (i_mstatus),
        .i_mie         (i_mie),
        .i_mtvec       (i_mtvec),
        .i_mepc        (i_mepc),
        .i_pipe_empty  (i_pipe_empty),
        .o_flush       (o_flush),
        .o_busy        (o_busy),
        .o_csr_we      (o_csr_we),
        .o_csr_waddr   (o_csr_waddr),
        .o_csr_wdata   (o_csr_wdata),
        .o_redirect    (o_redirect),
        .o_redirect_pc (o_redirect_pc)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic redir, input logic [11:0] addr, input logic [31:0] data);
        exp_t e;
        e.redir = redir;
        e.addr  = addr;
        e.data  = data;
        return e;
    endfunction

    // Monitor: every CSR write or redirect must match the head of the queue.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (o_csr_we) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_csr_write: got addr=%h data=%h, required none", o_csr_waddr, o_csr_wdata);
                end else begin
                    e = exp_q.pop_front();
                    if (e.redir !== 1'b0 || o_csr_waddr !== e.addr || o_csr_wdata !== e.data) begin
                        n_fail++;
                        $display("FAIL csr_write: got addr=%h data=%h, required redir=%b addr=%h data=%h",
                                 o_csr_waddr, o_csr_wdata, e.redir, e.addr, e.data);
                    end
                end
            end
            if (o_redirect) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_redirect: got pc=%h, required none", o_redirect_pc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.redir !== 1'b1 || o_redirect_pc !== e.data) begin
                        n_fail++;
                        $display("FAIL redirect: got pc=%h, required redir=%b pc=%h", o_redirect_pc, e.redir, e.data);
                    end
                end
            end
        end
    end

    task automatic idle_inputs();
        i_exc_valid = 1'b0; i_exc_vec = '0; i_exc_pc = '0; i_exc_tval = '0;
        i_mret = 1'b0; i_ext_intr = 1'b0; i_sw_intr = 1'b0; i_next_pc = '0;
        i_mstatus = '0; i_mie = '0; i_mtvec = '0; i_mepc = '0; i_pipe_empty = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({o_flush, o_busy, o_csr_we, o_redirect} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got flush/busy/we/redir=%b, required 0000", {o_flush, o_busy, o_csr_we, o_redirect});
        end
        n_checks++;
        if (o_csr_waddr !== 12'h0 || o_csr_wdata !== 32'h0 || o_redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got addr=%h data=%h pc=%h, required 0", o_csr_waddr, o_csr_wdata, o_redirect_pc);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got busy=%b, required 0", o_busy);
        end
    endtask

    task automatic test_illegal();
        int k;
        i_mstatus = 32'h8; i_mie = '0; i_mtvec = 32'h200; i_pipe_empty = 1'b1;
        exp_q.push_back(mk(1'b0, 12'h341, 32'h100));
        exp_q.push_back(mk(1'b0, 12'h342, 32'd2));
        exp_q.push_back(mk(1'b0, 12'h343, 32'h0000FFFF));
        exp_q.push_back(mk(1'b0, 12'h300, 32'h1880));
        exp_q.push_back(mk(1'b1, 12'h000, 32'h200));
        i_exc_valid = 1'b1; i_exc_vec = 6'b000010; i_exc_pc = 32'h100; i_exc_tval = 32'h0000FFFF;
        @(posedge clk);
        #1 i_exc_valid = 1'b0; i_exc_vec = '0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                n_checks++;
                if (o_flush !== 1'b1 || o_busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL illegal_drain: got flush=%b busy=%b, required 1 1", o_flush, o_busy);
                end
            end
        end while (!o_redirect && k < 20);
        n_checks++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL illegal_latency: got %0d cycles, required 6", k);
        end
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || o_flush !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL illegal_done: got busy=%b flush=%b pending=%0d, required 0 0 0", o_busy, o_flush, exp_q.size());
        end
    endtask

    task automatic test_ecall_load();
        int  k;
        logic extra;
        i_mstatus = 32'h0; i_mtvec = 32'h301; i_pipe_empty = 1'b1;
        exp_q.push_back(mk(1'b0, 12'h341, 32'h208));
        exp_q.push_back(mk(1'b0, 12'h342, 32'd11));
        exp_q.push_back(mk(1'b0, 12'h343, 32'h1234));
        exp_q.push_back(mk(1'b0, 12'h300, 32'h1800));
        exp_q.push_back(mk(1'b1, 12'h000, 32'h300));
        i_exc_valid = 1'b1; i_exc_vec = 6'b011000; i_exc_pc = 32'h208; i_exc_tval = 32'h1234;
        @(posedge clk);
        #1 i_exc_valid = 1'b0; i_exc_vec = '0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_redirect && k < 20);
        n_checks++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL ecall_latency: got %0d cycles, required 6", k);
        end
        extra = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (o_busy !== 1'b0) extra = 1'b1;
        end
        n_checks++;
        if (extra !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL ecall_single: got second_seq=%b pending=%0d, required 0 0", extra, exp_q.size());
        end
    endtask

    task automatic test_mei();
        int k;
        i_mstatus = 32'h8; i_mie = 32'h808; i_mtvec = 32'h301; i_next_pc = 32'h40; i_pipe_empty = 1'b1;
        exp_q.push_back(mk(1'b0, 12'h341, 32'h40));
        exp_q.push_back(mk(1'b0, 12'h342, 32'h8000000B));
        exp_q.push_back(mk(1'b0, 12'h343, 32'h0));
        exp_q.push_back(mk(1'b0, 12'h300, 32'h1880));
        exp_q.push_back(mk(1'b1, 12'h000, 32'h32C));
        i_ext_intr = 1'b1; i_sw_intr = 1'b1; i_exc_tval = 32'hDEAD;
        @(posedge clk);
        #1 i_ext_intr = 1'b0; i_sw_intr = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!o_redirect && k < 20);
        n_checks++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL mei_latency: got %0d cycles, required 6", k);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mei_done: got busy=%b pending=%0d, required 0 0", o_busy, exp_q.size());
        end
    endtask

    task automatic test_mei_masked();
        int  k;
        logic seen;
        i_mstatus = 32'h0; i_mie = 32'h800; i_mtvec = 32'h200; i_next_pc = 32'h80; i_pipe_empty = 1'b1;
        i_ext_intr = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || o_flush !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++;
            $display("FAIL mei_masked: got busy during masked interrupt, required idle");
        end
        exp_q.push_back(mk(1'b0, 12'h341, 32'h80));
        exp_q.push_back(mk(1'b0, 12'h342, 32'h8000000B));
        exp_q.push_back(mk(1'b0, 12'h343, 32'h0));
        exp_q.push_back(mk(1'b0, 12'h300, 32'h1880));
        exp_q.push_back(mk(1'b1, 12'h000, 32'h200));
        i_mstatus = 32'h8;
        @(posedge clk);
        #1 i_ext_intr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mei_unmask_start: got busy=%b, required 1", o_busy);
        end
        k = 0;
        while (o_busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (o_busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mei_unmask_done: got busy=%b pending=%0d, required 0 0", o_busy, exp_q.size());
        end
    endtask

    task automatic test_mret();
        int k;
        i_mstatus = 32'h80; i_mepc = 32'h104; i_mtvec = 32'h200;
        exp_q.push_back(mk(1'b0, 12'h300, 32'h1888));
        exp_q.push_back(mk(1'b1, 12'h000, 32'h104));
        i_mret = 1'b1;
        @(posedge clk);
        #1 i_mret = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                n_checks++;
                if (o_flush !== 1'b1 || o_csr_we !== 1'b1) begin
                    n_fail++;
                    $display("FAIL mret_status_cycle: got flush=%b we=%b, required 1 1", o_flush, o_csr_we);
                end
            end
        end while (!o_redirect && k < 20);
        n_checks++;
        if (k != 2) begin
            n_fail++;
            $display("FAIL mret_latency: got %0d cycles, required 2", k);
        end
        @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL mret_done: got busy=%b pending=%0d, required 0 0", o_busy, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int k;
        // ebreak and MRET together: exception wins; requests while busy are ignored
        i_mstatus = 32'h8; i_mtvec = 32'h200; i_mepc = 32'h500; i_pipe_empty = 1'b1;
        exp_q.push_back(mk(1'b0, 12'h341, 32'h300));
        exp_q.push_back(mk(1'b0, 12'h342, 32'd3));
        exp_q.push_back(mk(1'b0, 12'h343, 32'h0));
        exp_q.push_back(mk(1'b0, 12'h300, 32'h1880));
        exp_q.push_back(mk(1'b1, 12'h000, 32'h200));
        i_exc_valid = 1'b1; i_exc_vec = 6'b000100; i_exc_pc = 32'h302; i_exc_tval = 32'h0; i_mret = 1'b1;
        @(posedge clk);
        #1 i_exc_valid = 1'b0; i_exc_vec = '0; i_mret = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
            if (k == 2) begin
                i_exc_valid = 1'b1; i_exc_vec = 6'b000001; i_mret = 1'b1;
            end else begin
                i_exc_valid = 1'b0; i_exc_vec = '0; i_mret = 1'b0;
            end
        end while (!o_redirect && k < 20);
        n_checks++;
        if (k != 6) begin
            n_fail++;
            $display("FAIL b2b_latency: got %0d cycles, required 6", k);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (o_busy !== 1'b0 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_done: got busy=%b pending=%0d, required 0 0", o_busy, exp_q.size());
        end
    endtask

    task automatic test_drain_reset();
        logic quiet;
        i_mstatus = 32'h8; i_mtvec = 32'h200; i_pipe_empty = 1'b0;
        exp_q.push_back(mk(1'b0, 12'h341, 32'h100));
        exp_q.push_back(mk(1'b0, 12'h342, 32'd2));
        i_exc_valid = 1'b1; i_exc_vec = 6'b000010; i_exc_pc = 32'h103; i_exc_tval = 32'h0;
        @(posedge clk);
        #1 i_exc_valid = 1'b0; i_exc_vec = '0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            n_checks++;
            if (o_flush !== 1'b1 || o_csr_we !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_hold%0d: got flush=%b we=%b, required 1 0", c, o_flush, o_csr_we);
            end
        end
        i_pipe_empty = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({o_flush, o_busy, o_csr_we, o_redirect} !== 4'b0000 || o_csr_wdata !== 32'h0 || o_redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL midseq_reset: got flush/busy/we/redir=%b data=%h pc=%h, required 0",
                     {o_flush, o_busy, o_csr_we, o_redirect}, o_csr_wdata, o_redirect_pc);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (o_busy !== 1'b0 || o_csr_we !== 1'b0 || o_redirect !== 1'b0) quiet = 1'b0;
        end
        n_checks++;
        if (quiet !== 1'b1 || exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL after_reset_quiet: got quiet=%b pending=%0d, required 1 0", quiet, exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        test_reset();
        idle_inputs(); @(negedge clk);
        test_illegal();
        idle_inputs(); @(negedge clk);
        test_ecall_load();
        idle_inputs(); @(negedge clk);
        test_mei();
        idle_inputs(); @(negedge clk);
        test_mei_masked();
        idle_inputs(); @(negedge clk);
        test_mret();
        idle_inputs(); @(negedge clk);
        test_back_to_back();
        idle_inputs(); @(negedge clk);
        test_drain_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle controller that owns trap entry and MRET return for the machine-mode CSR file.
- Latches exception and interrupt requests from the pipeline and prioritises them.
- Drains and flushes the pipeline, then writes mepc, mcause, mtval and mstatus through the CSR file's single write port, one register per cycle.
- Finally issues a one-cycle PC redirect to the trap vector or to mepc; sits between the WB stage, the CSR file and the fetch PC mux.

Parameters:
N, 32, datapath and CSR width
CSR_MEPC, 12'h341, mepc address
CSR_MCAUSE, 12'h342, mcause address
CSR_MTVAL, 12'h343, mtval address
CSR_MSTATUS, 12'h300, mstatus address

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
i_exc_valid  in  1  WB-stage instruction raises a synchronous exception this cycle
i_exc_vec  in  6  {store_mis, load_mis, ecall, ebreak, illegal, pc_mis}
i_exc_pc  in  N  PC of excepting instruction
i_exc_tval  in  N  faulting address or instruction bits
i_mret  in  1  WB-stage MRET retires
i_ext_intr  in  1  level machine external interrupt
i_sw_intr  in  1  level machine software interrupt
i_next_pc  in  N  PC of next instruction to retire (interrupt mepc)
i_mstatus  in  N  current mstatus
i_mie  in  N  current mie
i_mtvec  in  N  current mtvec
i_mepc  in  N  current mepc
i_pipe_empty  in  1  pipeline holds no in-flight instructions
o_flush  out  1  kill IF/ID/EX and hold fetch
o_busy  out  1  sequencer not IDLE
o_csr_we  out  1  CSR write strobe
o_csr_waddr  out  12  CSR write address
o_csr_wdata  out  N  CSR write data
o_redirect  out  1  one-cycle PC load
o_redirect_pc  out  N  target PC

Behaviour:
- Reset: all outputs 0, state IDLE, captured cause/pc/tval regs 0. Reset mid-sequence abandons remaining CSR writes.
- Priority, evaluated in IDLE only; highest first:
  - exception: pc_mis (cause 0), illegal (2), ebreak (3), ecall (11), load_mis (4), store_mis (6)
  - then i_mret
  - then MEI (cause 0x8000000B, needs i_mstatus[3] & i_mie[11])
  - then MSI (0x80000003, needs i_mstatus[3] & i_mie[3])
- Exception beats a same-cycle MRET or interrupt. Interrupts are level sensitive, never queued; still-asserted interrupts are re-evaluated on return to IDLE.
- Capture on acceptance edge:
  - cause
  - epc: i_exc_pc for exceptions, i_next_pc for interrupts
  - tval: i_exc_tval for exceptions, 0 for interrupts
  - mstatus snapshot
- States and transitions:
  - IDLE: on a trap go to DRAIN; on MRET go to M_STATUS.
  - DRAIN: o_flush=1. Advance when i_pipe_empty=1; minimum 1 cycle.
  - W_EPC: we=1, addr=CSR_MEPC, data=epc & ~3.
  - W_CAUSE: addr=CSR_MCAUSE, data=cause.
  - W_TVAL: addr=CSR_MTVAL, data=tval.
  - W_STATUS: addr=CSR_MSTATUS, data=snapshot with MPIE(bit7)=MIE(bit3), MIE=0, MPP[12:11]=2'b11.
  - REDIRECT: o_redirect=1 for exactly 1 cycle, then IDLE.
  - M_STATUS: o_flush=1. Writes mstatus with MIE=MPIE, MPIE=1, MPP=11, then REDIRECT with pc=i_mepc & ~3.
- o_flush stays 1 from DRAIN through REDIRECT inclusive. o_busy=1 in every non-IDLE state.
- Trap target:
  - direct mode (mtvec[1:0]!=01): {mtvec[N-1:2],2'b00}
  - vectored mode, interrupt: base + 4*cause[4:0]
  - vectored mode, exception: base
  - addition wraps modulo 2^N
- Latency, i_pipe_empty already 1: trap takes 6 cycles from accept edge to redirect (DRAIN, 4 writes, REDIRECT); MRET takes 2.
- i_exc_valid and i_mret are ignored while busy; the pipeline is flushed, so none are legal.
- All outputs registered or decoded from state only; no combinational path from inputs to outputs.

Decomposition:
- parameter.vh holds:
  - cause-code constants
  - CSR address constants
  - mstatus bit-index constants (MIE=3, MPIE=7, MPP=12:11)
  - state encodings
- Sub-module trap_prio_enc: combinational. Takes i_exc_vec, interrupt enables and pending bits; returns take, is_intr, cause[N-1:0].

Test Plan:
- Illegal instruction, pc=0x100, tval=0x0000FFFF, mtvec=0x200 direct, pipe_empty=1 → writes mepc=0x100, mcause=2, mtval=0xFFFF, mstatus MIE 1→0 with MPIE=1; redirect 0x200 six cycles after accept.
- ecall and load_mis in the same cycle → mcause=11 only; single sequence.
- MEI with MIE=1, mie[11]=1, mtvec=0x301 vectored, next_pc=0x40 → mepc=0x40, mcause=0x8000000B, mtval=0, redirect 0x32C.
- MEI asserted with mstatus.MIE=0 → no trap, o_busy stays 0; setting MIE=1 → trap starts next cycle.
- MRET with mstatus MPIE=1, MIE=0, mepc=0x104 → mstatus write sets MIE=1, MPIE=1; redirect 0x104 two cycles after accept.
- i_pipe_empty held low 3 cycles in DRAIN, then assert rst mid-W_CAUSE → flush held 3+ cycles; after reset all outputs 0 and no further CSR writes.
